// File: rtl/pipe_stage_ctrl.sv
// N-stage pipeline sequencer: resolves stall/flush requests into per-stage enable/bubble controls,
// tracks per-stage valid bits and keeps saturating performance counters. Optional single-step debug: DEBUG_STEP_EN.
module pipe_stage_ctrl #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush_req,
    input  logic              cnt_clr,
`ifdef DEBUG_STEP_EN
    input  logic              debug_en,
    input  logic              debug_step,
`endif
    output logic [STAGES-1:0] stg_en,
    output logic [STAGES-1:0] stg_rst,
    output logic [STAGES-1:0] stg_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] sq, fq, shift_in;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    int unsigned       stall_idx, flush_idx;
    logic              stall_eff, flush_eff, retire;
    logic              run;

`ifdef DEBUG_STEP_EN
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= debug_step;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign run = !debug_en || (sync2_q && !prev_q);
`else
    assign run = 1'b1;
`endif

    always_comb begin
        sq        = stall_req & valid_q;
        fq        = flush_req & valid_q;
        stall_idx = 0;
        flush_idx = 0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (sq[i]) stall_idx = i;
            if (fq[i]) flush_idx = i;
        end
        // A flush from above the staller kills the staller; otherwise the flusher is held and its flush waits.
        flush_eff = (|fq) && (!(|sq) || flush_idx > stall_idx);
        stall_eff = (|sq) && !flush_eff;

        stg_en  = '1;
        stg_rst = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (stall_eff && i <= stall_idx)     stg_en[i]  = 1'b0;
            if (stall_eff && i == stall_idx + 1) stg_rst[i] = 1'b1;
            if (flush_eff && i < flush_idx)      stg_rst[i] = 1'b1;
        end
        stg_en = stg_en | stg_rst;
        if (!run) begin
            stg_en  = '0;
            stg_rst = '0;
        end
        if (!rst) begin
            stg_en  = '0;
            stg_rst = '1;
        end

        shift_in = {valid_q[STAGES-2:0], fetch_valid};
        valid_d  = valid_q;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (stg_rst[i])     valid_d[i] = 1'b0;
            else if (stg_en[i]) valid_d[i] = shift_in[i];
        end

        retire       = valid_q[STAGES-1] && stg_en[STAGES-1];
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (run) begin
            if (cnt_clr) begin
                stall_cnt_d  = '0;
                flush_cnt_d  = '0;
                retire_cnt_d = '0;
            end else begin
                if (stall_eff && stall_cnt_q != '1)  stall_cnt_d  = stall_cnt_q + CNT_W'(1);
                if (flush_eff && flush_cnt_q != '1)  flush_cnt_d  = flush_cnt_q + CNT_W'(1);
                if (retire && retire_cnt_q != '1)    retire_cnt_d = retire_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stg_valid  = valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl; a second instance with 3-bit counters covers saturation.
module tb_pipe_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [4:0]  stall_req, flush_req;
    logic        cnt_clr;
    logic [4:0]  stg_en, stg_rst, stg_valid;
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;
    logic [4:0]  n_en, n_rst, n_valid;
    logic [2:0]  n_stall_cnt, n_flush_cnt, n_retire_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(.STAGES(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
        .stall_req(stall_req), .flush_req(flush_req), .cnt_clr(cnt_clr),
`ifdef DEBUG_STEP_EN
        .debug_en(1'b0), .debug_step(1'b0),
`endif
        .stg_en(stg_en), .stg_rst(stg_rst), .stg_valid(stg_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    pipe_stage_ctrl #(.STAGES(5), .CNT_W(3)) dut_n (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
        .stall_req(stall_req), .flush_req(flush_req), .cnt_clr(cnt_clr),
`ifdef DEBUG_STEP_EN
        .debug_en(1'b0), .debug_step(1'b0),
`endif
        .stg_en(n_en), .stg_rst(n_rst), .stg_valid(n_valid),
        .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt), .retire_cnt(n_retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] fill_exp [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        fill_exp = '{5'b00001, 5'b00011, 5'b00111, 5'b01110,
                     5'b11100, 5'b11000, 5'b10000, 5'b00000};
        rst = 1'b0; fetch_valid = 1'b0; stall_req = '0; flush_req = '0; cnt_clr = 1'b0;
        #2;
        check("rst_valid",  {27'd0, stg_valid}, 32'h0);
        check("rst_stgrst", {27'd0, stg_rst},   32'h1f);
        check("rst_stgen",  {27'd0, stg_en},    32'h0);
        check("rst_retire", retire_cnt,         32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            fetch_valid = (i < 3);
            step();
            check($sformatf("fill_%0d", i), {27'd0, stg_valid}, {27'd0, fill_exp[i]});
        end
        check("fill_retire", retire_cnt, 32'd3);

        fetch_valid = 1'b1;
        repeat (5) step();
        check("refill_valid", {27'd0, stg_valid}, 32'h1f);

        stall_req = 5'b00100;
        #1;
        check("lu_en",  {27'd0, stg_en},  32'h18);
        check("lu_rst", {27'd0, stg_rst}, 32'h08);
        step();
        check("lu_valid",  {27'd0, stg_valid}, 32'h17);
        check("lu_stall",  stall_cnt,  32'd1);
        check("lu_retire", retire_cnt, 32'd4);
        stall_req = '0;
        step();
        check("lu2_valid", {27'd0, stg_valid}, 32'h0f);

        stall_req = 5'b00010; flush_req = 5'b00100;
        #1;
        check("bf_rst", {27'd0, stg_rst}, 32'h03);
        check("bf_en",  {27'd0, stg_en},  32'h1f);
        step();
        check("bf_valid", {27'd0, stg_valid}, 32'h1c);
        check("bf_stall", stall_cnt, 32'd1);
        check("bf_flush", flush_cnt, 32'd1);

        stall_req = 5'b01000; flush_req = 5'b00100;
        #1;
        check("df_rst", {27'd0, stg_rst}, 32'h10);
        check("df_en",  {27'd0, stg_en},  32'h10);
        step();
        check("df_valid",  {27'd0, stg_valid}, 32'h0c);
        check("df_stall",  stall_cnt,  32'd2);
        check("df_flush",  flush_cnt,  32'd1);
        check("df_retire", retire_cnt, 32'd6);

        stall_req = '0; flush_req = '0; fetch_valid = 1'b0;
        step();
        step();
        check("inv_pre", {27'd0, stg_valid}, 32'h10);
        stall_req = 5'b01000;
        #1;
        check("inv_en",  {27'd0, stg_en},  32'h1f);
        check("inv_rst", {27'd0, stg_rst}, 32'h00);
        step();
        check("inv_stall",  stall_cnt,  32'd2);
        check("inv_retire", retire_cnt, 32'd8);
        stall_req = '0;

        cnt_clr = 1'b1; fetch_valid = 1'b1;
        step();
        check("clr_retire",   retire_cnt,            32'd0);
        check("clr_n_retire", {29'd0, n_retire_cnt}, 32'd0);
        cnt_clr = 1'b0;
        repeat (13) step();
        check("sat_retire",   retire_cnt,            32'd9);
        check("sat_n_retire", {29'd0, n_retire_cnt}, 32'd7);
        cnt_clr = 1'b1;
        step();
        check("clrpri_retire",   retire_cnt,            32'd0);
        check("clrpri_n_retire", {29'd0, n_retire_cnt}, 32'd0);
        cnt_clr = 1'b0;
        step();
        check("mid_pre_retire", retire_cnt, 32'd1);
        check("mid_pre_valid",  {27'd0, stg_valid}, 32'h1f);

        #3 rst = 1'b0;
        #1;
        check("mid_valid",  {27'd0, stg_valid}, 32'h0);
        check("mid_retire", retire_cnt,         32'h0);
        check("mid_stgrst", {27'd0, stg_rst},   32'h1f);
        check("mid_stgen",  {27'd0, stg_en},    32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
